comp_bist: RTL and testbench
============================

COMP_BIST -- requirements
Module: comp_bist

Interface
REQ-001 SHALL have parameter WIDTH, default 1: operand width driven to the comparator under test.
REQ-002 SHALL have parameter LAT, default 1, legal range >= 1: number of cycles each vector settles before its result is sampled.
REQ-003 SHALL have parameter ERRW, default 8: width of the error counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin a sweep.
REQ-007 SHALL have ports a_out and b_out, outputs, WIDTH bits each: operands driven to the comparator.
REQ-008 SHALL have ports greater_in, lesser_in and equal_in, inputs, 1 bit each: the comparator's responses.
REQ-009 SHALL have port busy, output, 1 bit: a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: a sweep has completed; sticky until the next start or reset.
REQ-011 SHALL have port pass, output, 1 bit: the completed sweep had zero mismatches; valid only while done=1.
REQ-012 SHALL have port err_count, output, ERRW bits: number of mismatching vectors in the sweep.
REQ-013 SHALL have ports fail_a and fail_b, outputs, WIDTH bits each: operands of the first mismatching vector.
REQ-014 SHALL have port fail_valid, output, 1 bit: fail_a and fail_b hold a captured mismatch.

Function
REQ-015 SHALL implement states IDLE, DRIVE, CHECK and DONE.
REQ-016 SHALL move from IDLE or DONE to DRIVE on start=1; start SHALL be ignored in DRIVE and CHECK.
REQ-017 SHALL, on accepting start, set vector index vec=0 and clear err_count, fail_valid, fail_a and fail_b.
REQ-018 SHALL drive a_out=vec[2*WIDTH-1:WIDTH] and b_out=vec[WIDTH-1:0] (a is the major field), registered, stable through DRIVE and CHECK.
REQ-019 SHALL hold DRIVE for exactly LAT cycles, then spend one cycle in CHECK.
REQ-020 SHALL sample the three response inputs at the rising edge that ends CHECK.
REQ-021 SHALL take the expected response as greater=(a_out>b_out), lesser=(a_out<b_out), equal=(a_out==b_out), unsigned.
REQ-022 SHALL count a vector as a mismatch if any of the three response bits differs from expected; this includes non-one-hot responses.
REQ-023 SHALL increment err_count on each mismatch and saturate it at 2^ERRW-1, with no wrap.
REQ-024 SHALL load fail_a, fail_b and fail_valid=1 on the first mismatch only.
REQ-025 SHALL, after CHECK, increment vec and return to DRIVE; if vec was 2^(2*WIDTH)-1, it SHALL go to DONE instead.
REQ-026 SHALL run each sweep for (LAT+1)*2^(2*WIDTH) cycles, measured from the first DRIVE cycle to the first DONE cycle.
REQ-027 SHALL drive busy=1 in DRIVE and CHECK, and done=1 only in DONE.
REQ-028 SHALL drive pass = done and (err_count==0).
REQ-029 SHALL hold a_out and b_out at their last values in DONE, and at 0 in IDLE.
REQ-030 SHALL treat start=1 while in DONE as a restart, applying REQ-017 and entering DRIVE on the next cycle.

Reset
REQ-031 SHALL, while rst=1 at a rising edge, force state=IDLE, vec=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_a=0 and fail_b=0.
REQ-032 SHALL let reset override start and abort any sweep in progress, with no partial result retained.

Structure
REQ-033 SHALL place the state enumeration, the state encoding and the saturation-limit helper in shared package comp_pkg.
REQ-034 SHALL compute the expected response in one combinational sub-module, comp_ref, with inputs a and b and outputs greater, lesser and equal.

Verification
REQ-035 SHALL cover: WIDTH=1, LAT=1, correct comparator model, start pulse -> busy for 8 cycles, done=1, pass=1, err_count=0, vectors seen in the order 00, 01, 10, 11.
REQ-036 SHALL cover: WIDTH=1, greater_in stuck at 0 -> err_count=1, fail_a=1, fail_b=0, fail_valid=1, pass=0.
REQ-037 SHALL cover: WIDTH=1, equal_in stuck at 1 -> err_count=2 (vectors 01 and 10), fail_a=0, fail_b=1.
REQ-038 SHALL cover: WIDTH=2, ERRW=2, all responses inverted -> 16 mismatches, err_count saturates at 3, fail_a=0, fail_b=0.
REQ-039 SHALL cover: rst=1 during CHECK of vector 2 -> all outputs zero next cycle; a later start produces a full clean sweep with pass=1.
REQ-040 SHALL cover: start=1 held throughout a sweep -> no restart while busy; restart in the first cycle after DONE is entered, with err_count cleared.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared definitions for the comparator self-test: state encoding and the
// error-counter saturation limit.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_t;

  // All-ones value of a w-bit counter; widths of 32 or more clamp to 32 bits.
  function automatic logic [31:0] sat_limit(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/comp_ref.sv
// Golden unsigned magnitude comparator used to judge the device under test.
module comp_ref #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater,
  output logic             lesser,
  output logic             equal
);

  assign greater = (a > b);
  assign lesser  = (a < b);
  assign equal   = (a == b);

endmodule

// File: rtl/comp_bist.sv
// Exhaustive sweep of every (a, b) operand pair through an external
// comparator, counting mismatches and capturing the first failing vector.
module comp_bist
  import comp_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LAT   = 1,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             greater_in,
  input  logic             lesser_in,
  input  logic             equal_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_valid
);

  localparam int VW = 2 * WIDTH;
  localparam int LW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [ERRW-1:0] ERR_MAX = ERRW'(sat_limit(ERRW));

  state_t          state;
  logic [VW-1:0]   vec;
  logic [VW-1:0]   vec_next;
  logic [LW-1:0]   lat_cnt;
  logic            exp_greater;
  logic            exp_lesser;
  logic            exp_equal;
  logic            mismatch;
  logic [ERRW-1:0] err_inc;

  comp_ref #(.WIDTH(WIDTH)) u_ref (
    .a       (a_out),
    .b       (b_out),
    .greater (exp_greater),
    .lesser  (exp_lesser),
    .equal   (exp_equal)
  );

  assign vec_next = vec + 1'b1;
  assign mismatch = ({greater_in, lesser_in, equal_in} != {exp_greater, exp_lesser, exp_equal});
  assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      lat_cnt    <= '0;
      a_out      <= '0;
      b_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            vec        <= '0;
            lat_cnt    <= '0;
            a_out      <= '0;
            b_out      <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
          end
        end
        DRIVE: begin
          if (lat_cnt == LW'(LAT - 1)) state <= CHECK;
          else lat_cnt <= lat_cnt + 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_out;
              fail_b     <= b_out;
            end
          end
          if (vec == '1) begin
            // Operands stay on the last vector while the result is held.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == '0);
          end else begin
            state          <= DRIVE;
            vec            <= vec_next;
            lat_cnt        <= '0;
            {a_out, b_out} <= vec_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_bist.sv
// Randomized self-check of comp_bist against a sweep-timeline model, on a
// 1-bit/LAT=1 instance and a 2-bit/LAT=2/ERRW=2 instance sharing rst/start.
module tb_comp_bist;

  localparam int W [2] = '{1, 2};
  localparam int L [2] = '{1, 2};
  localparam int E [2] = '{8, 2};

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  int         mode [2];
  logic [2:0] tbl [2][16];

  logic       a1, b1, g1, l1, e1, busy1, done1, pass1, fv1, fa1, fb1;
  logic [7:0] err1;
  logic [1:0] a2, b2, fa2, fb2, err2;
  logic       g2, l2, e2, busy2, done2, pass2, fv2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Comparator responses: 0 ideal, 1 greater stuck 0, 2 equal stuck 1,
  // 3 all inverted, 4 per-vector xor mask from a table.
  function automatic logic [2:0] resp(int md, logic [2:0] m, int a, int b);
    logic [2:0] ideal;
    ideal = {a > b, a < b, a == b};
    case (md)
      0: return ideal;
      1: return ideal & 3'b011;
      2: return ideal | 3'b001;
      3: return ~ideal;
      default: return ideal ^ m;
    endcase
  endfunction

  always_comb {g1, l1, e1} = resp(mode[0], tbl[0][4'({a1, b1})], int'(a1), int'(b1));
  always_comb {g2, l2, e2} = resp(mode[1], tbl[1][4'({a2, b2})], int'(a2), int'(b2));

  comp_bist #(.WIDTH(1), .LAT(1), .ERRW(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1),
    .greater_in(g1), .lesser_in(l1), .equal_in(e1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1), .fail_valid(fv1)
  );

  comp_bist #(.WIDTH(2), .LAT(2), .ERRW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a_out(a2), .b_out(b2),
    .greater_in(g2), .lesser_in(l2), .equal_in(e2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2), .fail_valid(fv2)
  );

  // Model: phase 0 idle, 1 sweeping (t = cycles since first DRIVE), 2 done.
  int         ph [2];
  int         t  [2];
  int         sm [2];
  logic [2:0] stbl [2][16];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] <= 0;
        t[i]  <= 0;
      end else if ((ph[i] != 1) && start) begin
        ph[i] <= 1;
        t[i]  <= 0;
        sm[i] <= mode[i];
        for (int j = 0; j < 16; j++) stbl[i][j] <= tbl[i][j];
      end else if (ph[i] == 1) begin
        if (t[i] + 1 == (L[i] + 1) * (1 << (2 * W[i]))) ph[i] <= 2;
        else t[i] <= t[i] + 1;
      end
    end
  end

  task automatic expect_out(input int i, output int ea, output int eb, output int ebusy,
                            output int edone, output int epass, output int eerr,
                            output int efv, output int efa, output int efb);
    int n, kc, nchk, cnt, first, a, b;
    n = 1 << (2 * W[i]);
    cnt = 0; first = -1;
    ea = 0; eb = 0; ebusy = 0; edone = 0; epass = 0; eerr = 0; efv = 0; efa = 0; efb = 0;
    if (ph[i] == 0) return;
    if (ph[i] == 1) begin
      kc = t[i] / (L[i] + 1); nchk = kc; ebusy = 1;
    end else begin
      kc = n - 1; nchk = n; edone = 1;
    end
    ea = kc >> W[i];
    eb = kc & ((1 << W[i]) - 1);
    for (int k = 0; k < nchk; k++) begin
      a = k >> W[i];
      b = k & ((1 << W[i]) - 1);
      if (resp(sm[i], stbl[i][k], a, b) != resp(0, 3'b000, a, b)) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    eerr  = (cnt > (1 << E[i]) - 1) ? (1 << E[i]) - 1 : cnt;
    efv   = (first >= 0) ? 1 : 0;
    efa   = (first >= 0) ? first >> W[i] : 0;
    efb   = (first >= 0) ? first & ((1 << W[i]) - 1) : 0;
    epass = (edone == 1 && cnt == 0) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ea, eb, ebu, edo, epa, eer, efv, efa, efb;
        int ga, gb, gbu, gdo, gpa, ger, gfv, gfa, gfb;
        expect_out(i, ea, eb, ebu, edo, epa, eer, efv, efa, efb);
        if (i == 0) begin
          ga = a1; gb = b1; gbu = busy1; gdo = done1; gpa = pass1;
          ger = err1; gfv = fv1; gfa = fa1; gfb = fb1;
        end else begin
          ga = a2; gb = b2; gbu = busy2; gdo = done2; gpa = pass2;
          ger = err2; gfv = fv2; gfa = fa2; gfb = fb2;
        end
        checks++;
        if ({ga, gb, gbu, gdo, gpa, ger, gfv, gfa, gfb} !=
            {ea, eb, ebu, edo, epa, eer, efv, efa, efb}) begin
          errors++;
          $display("FAIL model_dut%0d @%0t got a=%0d b=%0d busy=%0d done=%0d pass=%0d err=%0d fv=%0d fa=%0d fb=%0d exp a=%0d b=%0d busy=%0d done=%0d pass=%0d err=%0d fv=%0d fa=%0d fb=%0d",
                   i + 1, $time, ga, gb, gbu, gdo, gpa, ger, gfv, gfa, gfb,
                   ea, eb, ebu, edo, epa, eer, efv, efa, efb);
        end
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
    $display("check %s = %0d", name, got);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_both(input string name);
    int c;
    c = 0;
    while (!(done1 && done2) && c < 200) begin
      @(negedge clk); c++;
    end
    #1;
    lit({name, "_finished"}, int'(done1 && done2), 1);
  endtask

  initial begin
    int nb, c;
    logic [1:0] seen [$];
    rst = 1'b1; start = 1'b0;
    mode = '{0, 0};
    for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) tbl[i][j] = 3'b000;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1;
    lit("rst_busy1", busy1, 0); lit("rst_done2", done2, 0);
    lit("rst_err1", err1, 0);   lit("rst_a2", a2, 0);
    rst = 1'b0;

    // Clean sweep on dut1, all-inverted on dut2 (saturating counter).
    mode = '{0, 3};
    pulse_start();
    nb = 0; c = 0;
    while (!(done1 && done2) && c < 200) begin
      if (busy1) begin
        nb++;
        if (seen.size() == 0 || seen[$] != {a1, b1}) seen.push_back({a1, b1});
      end
      @(negedge clk); c++;
    end
    #1;
    lit("clean_busy_cycles", nb, 8);
    lit("clean_nvec", seen.size(), 4);
    for (int k = 0; k < seen.size() && k < 4; k++) lit($sformatf("clean_vec%0d", k), int'(seen[k]), k);
    lit("clean_done", done1, 1); lit("clean_pass", pass1, 1); lit("clean_err", err1, 0);
    lit("inv_err_sat", err2, 3); lit("inv_fa", fa2, 0); lit("inv_fb", fb2, 0);
    lit("inv_fv", fv2, 1); lit("inv_pass", pass2, 0);

    // greater_in stuck at 0.
    mode = '{1, 0};
    pulse_start(); wait_both("g0");
    lit("g0_err", err1, 1); lit("g0_fa", fa1, 1); lit("g0_fb", fb1, 0);
    lit("g0_fv", fv1, 1); lit("g0_pass", pass1, 0); lit("ok2_pass", pass2, 1);

    // equal_in stuck at 1.
    mode = '{2, 2};
    pulse_start(); wait_both("e1");
    lit("e1_err", err1, 2); lit("e1_fa", fa1, 0); lit("e1_fb", fb1, 1);

    // Reset during CHECK of vector 2 on dut1, then a clean sweep.
    mode = '{0, 0};
    pulse_start();
    repeat (5) @(negedge clk);
    lit("abort_a_before", a1, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    lit("abort_busy", busy1, 0); lit("abort_a", a1, 0); lit("abort_err", err1, 0);
    lit("abort_busy2", busy2, 0);
    rst = 1'b0;
    pulse_start(); wait_both("after_abort");
    lit("after_abort_pass", pass1, 1);

    // start held high: no restart while busy, restart right after DONE.
    mode = '{1, 0};
    @(negedge clk); start = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!done1 && c < 50);
    #1;
    lit("hold_len", c, 9); lit("hold_done_err", err1, 1);
    @(negedge clk); #1;
    lit("hold_restart_busy", busy1, 1); lit("hold_restart_err", err1, 0);
    lit("hold_restart_done", done1, 0);
    start = 1'b0;
    wait_both("hold");

    // Random comparator faults with random start lengths and idle gaps.
    for (int r = 0; r < 8; r++) begin
      mode = '{4, 4};
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 16; j++)
          tbl[i][j] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk); start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
      wait_both($sformatf("rand%0d", r));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
